// File: rtl/elastic_shift_reg.sv
// -----------------------------------------------------------------------------
// elastic_shift_reg
//
// N-stage shift register with a valid tag per stage and a ready/valid handshake
// on both ends. Intended as a drop-in for plain enable-driven delay chains in
// pipeline delay paths and writeback/commit queues.
//
//   ELASTIC = 1 : each stage advances on its own; bubbles are squeezed out as
//                 entries pack toward the output while the consumer stalls.
//   ELASTIC = 0 : every stage shifts in lockstep; a bubble in a middle stage
//                 stays a bubble, and a stalled output freezes the whole pipe.
//
// Stage 0 is the input side, stage N-1 the output side.
//
// Parameters
//   WIDTH    payload width in bits (>= 1)
//   N        number of stages (>= 1)
//   ELASTIC  1: per-stage advance with bubble collapse, 0: lockstep shift
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset (clears valid and payload)
//   flush        synchronous clear of every stage valid bit, payload held
//   in_valid     producer presents data_in
//   in_ready     stage 0 can accept this cycle (combinational from out_ready
//                and flush)
//   data_in      input payload
//   out_valid    stage N-1 holds an entry and no flush is in progress
//   out_ready    consumer takes data_out this cycle
//   data_out     payload of stage N-1 (stale when out_valid is low)
//   stage_valid  bit i = valid of stage i
//   stage_data   bits [i*WIDTH +: WIDTH] = payload of stage i
//   count        number of occupied stages
// -----------------------------------------------------------------------------
module elastic_shift_reg #(
    parameter int WIDTH   = 32,
    parameter int N       = 1,
    parameter int ELASTIC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         data_out,
    output logic [N-1:0]             stage_valid,
    output logic [N*WIDTH-1:0]       stage_data,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int CW = $clog2(N + 1);

    // Number of set bits in a stage-valid vector.
    function automatic logic [CW-1:0] popcount(input logic [N-1:0] vec);
        logic [CW-1:0] acc;
        acc = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            acc = acc + CW'(vec[i]);
        end
        return acc;
    endfunction

    // Stage state: valid tag and payload per stage.
    logic [N-1:0]            v_q;
    logic [N-1:0]            v_d;
    logic [N-1:0][WIDTH-1:0] d_q;
    logic [N-1:0][WIDTH-1:0] d_d;

    // Per-stage advance enables.
    logic [N-1:0]            adv_s;

    // Stage inputs: index i holds what stage i would load, so index 0 is the
    // producer and index i (i >= 1) is stage i-1. This avoids a stage -1
    // special case inside the update loop.
    logic [N:0]              v_ext_s;
    logic [N:0][WIDTH-1:0]   d_ext_s;

    assign v_ext_s = {v_q, in_valid};
    assign d_ext_s = {d_q, data_in};

    // Advance enables. In elastic mode the chain is walked from the output side
    // through a scalar carry so the vector is never read back while it is being
    // built; a stage may move whenever it is empty or the stage ahead moves.
    always_comb begin
        logic carry_s;
        adv_s   = {N{1'b0}};
        carry_s = ~v_q[N-1] | out_ready;
        if (ELASTIC != 0) begin
            adv_s[N-1] = carry_s;
            for (int i = N - 2; i >= 0; i--) begin
                carry_s  = ~v_q[i] | carry_s;
                adv_s[i] = carry_s;
            end
        end else begin
            // Lockstep: every stage follows the output stage's ability to drain.
            adv_s = {N{carry_s}};
        end
    end

    // Next-state for valid tags and payload. Flush clears the tags only; a
    // bubble moving into a stage clears its tag but leaves the payload alone.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = {N{1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                if (adv_s[i]) begin
                    v_d[i] = v_ext_s[i];
                    if (v_ext_s[i]) begin
                        d_d[i] = d_ext_s[i];
                    end else begin
                        d_d[i] = d_q[i];
                    end
                end else begin
                    v_d[i] = v_q[i];
                    d_d[i] = d_q[i];
                end
            end
        end
    end

    // Stage registers with asynchronous reset of tags and payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= {N{1'b0}};
            d_q <= {(N*WIDTH){1'b0}};
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    // Handshake outputs. Both ends are gated by flush so nothing transfers in
    // the cycle the pipe is being cleared; an input offered then must retry.
    assign in_ready    = adv_s[0] & ~flush;
    assign out_valid   = v_q[N-1] & ~flush;
    assign data_out    = d_q[N-1];

    // Taps for hazard and forwarding checks.
    assign stage_valid = v_q;
    assign stage_data  = d_q;
    assign count       = popcount(v_q);

endmodule

// File: tb/tb_elastic_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_shift_reg
//
// Directed bench for elastic_shift_reg. Two N=4, WIDTH=8 instances share all
// inputs: u_el (ELASTIC=1) and u_rg (ELASTIC=0). Expected values are written
// out by hand for each step. Inputs change and outputs are sampled shortly
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_elastic_shift_reg;

    localparam int W  = 8;
    localparam int NS = 4;

    logic           clk;
    logic           reset;
    logic           flush;
    logic           in_valid;
    logic           out_ready;
    logic [W-1:0]   data_in;

    logic           el_in_ready,  rg_in_ready;
    logic           el_out_valid, rg_out_valid;
    logic [W-1:0]   el_data_out,  rg_data_out;
    logic [NS-1:0]  el_sv,        rg_sv;
    logic [NS*W-1:0] el_sd,       rg_sd;
    logic [2:0]     el_cnt,       rg_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    elastic_shift_reg #(.WIDTH(W), .N(NS), .ELASTIC(1)) u_el (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(el_in_ready), .data_in(data_in),
        .out_valid(el_out_valid), .out_ready(out_ready), .data_out(el_data_out),
        .stage_valid(el_sv), .stage_data(el_sd), .count(el_cnt)
    );

    elastic_shift_reg #(.WIDTH(W), .N(NS), .ELASTIC(0)) u_rg (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rg_in_ready), .data_in(data_in),
        .out_valid(rg_out_valid), .out_ready(out_ready), .data_out(rg_data_out),
        .stage_valid(rg_sv), .stage_data(rg_sd), .count(rg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = 8'h00;
        #2;
        // Reset state
        chk("rst_el_ovalid", 32'(el_out_valid), 32'd0);
        chk("rst_el_count",  32'(el_cnt),       32'd0);
        chk("rst_el_sv",     32'(el_sv),        32'd0);
        chk("rst_el_sd",     el_sd,             32'd0);
        chk("rst_el_dout",   32'(el_data_out),  32'd0);
        chk("rst_el_iready", 32'(el_in_ready),  32'd1);
        chk("rst_rg_sd",     rg_sd,             32'd0);
        chk("rst_rg_iready", 32'(rg_in_ready),  32'd1);
        #1 reset = 1'b0;

        // Test 1: stream 0x01..0x08, out_ready held high
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            data_in = 8'(k);
            tick();
            chk("t1_el_ovalid", 32'(el_out_valid), (k >= 4) ? 32'd1 : 32'd0);
            chk("t1_rg_ovalid", 32'(rg_out_valid), (k >= 4) ? 32'd1 : 32'd0);
            chk("t1_el_count",  32'(el_cnt), (k >= 4) ? 32'd4 : 32'(k));
            if (k >= 4) begin
                chk("t1_el_dout", 32'(el_data_out), 32'(k - 3));
                chk("t1_rg_dout", 32'(rg_data_out), 32'(k - 3));
            end
        end
        in_valid = 1'b0;
        for (int k = 9; k <= 12; k++) begin
            tick();
            chk("t1d_el_count",  32'(el_cnt), 32'(12 - k));
            chk("t1d_el_ovalid", 32'(el_out_valid), (k <= 11) ? 32'd1 : 32'd0);
            chk("t1d_el_dout",   32'(el_data_out), (k <= 11) ? 32'(k - 3) : 32'd8);
        end

        // Tests 2/3: A1, bubble, A2, bubble with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = 8'hA1; tick();
        in_valid = 1'b0;                  tick();
        in_valid = 1'b1; data_in = 8'hA2; tick();
        in_valid = 1'b0;                  tick();
        #1;
        chk("t2_el_sv_e4",   32'(el_sv),       32'hA);
        chk("t2_el_iready4", 32'(el_in_ready), 32'd1);
        chk("t3_rg_sv_e4",   32'(rg_sv),       32'hA);
        chk("t3_rg_iready4", 32'(rg_in_ready), 32'd0);
        tick();
        chk("t2_el_sv_e5",   32'(el_sv),       32'hC);
        chk("t3_rg_sv_e5",   32'(rg_sv),       32'hA);
        tick();
        chk("t2_el_sv_e6",   32'(el_sv),       32'hC);
        chk("t2_el_iready6", 32'(el_in_ready), 32'd1);
        chk("t3_rg_iready6", 32'(rg_in_ready), 32'd0);
        chk("t3_rg_count6",  32'(rg_cnt),      32'd2);
        in_valid = 1'b1; data_in = 8'hA3; tick();
        chk("t2_el_sv_e7",   32'(el_sv),       32'hD);
        data_in = 8'hA4; tick();
        data_in = 8'hA5;
        #1;
        chk("t2_el_sv_full", 32'(el_sv),       32'hF);
        chk("t2_el_iready",  32'(el_in_ready), 32'd0);
        chk("t2_el_count",   32'(el_cnt),      32'd4);
        chk("t2_el_sd",      el_sd,            32'hA1A2A3A4);
        chk("t2_el_top",     32'(el_sd[31:24]), 32'hA1);
        chk("t3_rg_sv",      32'(rg_sv),       32'hA);
        chk("t3_rg_count",   32'(rg_cnt),      32'd2);
        chk("t3_rg_iready",  32'(rg_in_ready), 32'd0);
        chk("t3_rg_sd",      rg_sd,            32'hA1A1A2A2);
        tick();
        chk("t2_el_hold_sd", el_sd,            32'hA1A2A3A4);
        chk("t3_rg_hold_sd", rg_sd,            32'hA1A1A2A2);

        // Test 4: full elastic pipe, out_ready and in_valid high for 3 cycles
        out_ready = 1'b1;
        #1;
        chk("t4_el_iready",  32'(el_in_ready), 32'd1);
        chk("t4_el_dout0",   32'(el_data_out), 32'hA1);
        tick();
        chk("t4_el_count1",  32'(el_cnt),      32'd4);
        chk("t4_el_dout1",   32'(el_data_out), 32'hA2);
        data_in = 8'hA6; tick();
        chk("t4_el_count2",  32'(el_cnt),      32'd4);
        chk("t4_el_dout2",   32'(el_data_out), 32'hA3);
        data_in = 8'hA7; tick();
        chk("t4_el_count3",  32'(el_cnt),      32'd4);
        chk("t4_el_sd",      el_sd,            32'hA4A5A6A7);
        chk("t4_rg_sv",      32'(rg_sv),       32'h7);
        chk("t4_rg_count",   32'(rg_cnt),      32'd3);

        // Test 5: drain one to reach count 3, then flush with in_valid high
        in_valid = 1'b0; tick();
        chk("t5_el_sv_pre",  32'(el_sv),       32'hE);
        chk("t5_rg_sv_pre",  32'(rg_sv),       32'hE);
        flush = 1'b1; in_valid = 1'b1; data_in = 8'hB0;
        #1;
        chk("t5_el_iready",  32'(el_in_ready),  32'd0);
        chk("t5_el_ovalid",  32'(el_out_valid), 32'd0);
        chk("t5_rg_iready",  32'(rg_in_ready),  32'd0);
        chk("t5_rg_ovalid",  32'(rg_out_valid), 32'd0);
        chk("t5_el_count_f", 32'(el_cnt),       32'd3);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("t5_el_count",   32'(el_cnt),       32'd0);
        chk("t5_el_sv",      32'(el_sv),        32'd0);
        chk("t5_el_sd",      el_sd,             32'hA5A6A7A7);
        chk("t5_rg_sd",      rg_sd,             32'hA5A6A7A7);
        chk("t5_el_ovalid2", 32'(el_out_valid), 32'd0);
        chk("t5_el_dout",    32'(el_data_out),  32'hA5);
        chk("t5_el_iready2", 32'(el_in_ready),  32'd1);

        // Test 6: asynchronous reset between edges mid-stream
        in_valid = 1'b1; data_in = 8'hC1; tick();
        data_in = 8'hC2; tick();
        #1;
        chk("t6_el_sv_pre",  32'(el_sv),        32'h3);
        #1 reset = 1'b1;
        #1;
        chk("t6_el_ovalid",  32'(el_out_valid), 32'd0);
        chk("t6_el_sv",      32'(el_sv),        32'd0);
        chk("t6_el_count",   32'(el_cnt),       32'd0);
        chk("t6_el_sd",      el_sd,             32'd0);
        chk("t6_rg_sd",      rg_sd,             32'd0);
        #1 reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            data_in = 8'(8'h10 + k);
            tick();
            chk("t6_el_ovalid_r", 32'(el_out_valid), (k >= 4) ? 32'd1 : 32'd0);
            chk("t6_rg_ovalid_r", 32'(rg_out_valid), (k >= 4) ? 32'd1 : 32'd0);
            if (k >= 4) begin
                chk("t6_el_dout_r", 32'(el_data_out), 32'(8'h10 + k - 3));
                chk("t6_rg_dout_r", 32'(rg_data_out), 32'(8'h10 + k - 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
